// File: rtl/fetch_pc_unit_pkg.sv
// Shared definitions for the fetch PC unit.
//   fetch_state_e : fetch FSM states
//   INSTR_W       : instruction / address width
//   PC_INCR       : sequential PC step
package fetch_pc_unit_pkg;

    localparam int unsigned INSTR_W = 32;
    localparam logic [INSTR_W-1:0] PC_INCR = 32'd4;

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        DISCARD,
        HOLD
    } fetch_state_e;

endpackage

// File: rtl/fetch_pc_unit_pc_target_calc.sv
// Redirect target calculation (purely combinational).
//   ex_pc_plus4 : PC+4 of the redirecting instruction
//   signimm_sh  : sign-extended immediate, already shifted left by 2
//   jump_index  : instruction bits [25:0]
//   jump        : select the jump target instead of the branch target
//   target      : selected redirect address (mod 2^32)
module pc_target_calc
    import fetch_pc_unit_pkg::*;
(
    input  logic [INSTR_W-1:0] ex_pc_plus4,
    input  logic [INSTR_W-1:0] signimm_sh,
    input  logic [25:0]        jump_index,
    input  logic               jump,
    output logic [INSTR_W-1:0] target
);

    logic [INSTR_W-1:0] w_branch_target;
    logic [INSTR_W-1:0] w_jump_target;

    assign w_branch_target = ex_pc_plus4 + signimm_sh;
    assign w_jump_target   = {ex_pc_plus4[31:28], jump_index, 2'b00};
    assign target          = jump ? w_jump_target : w_branch_target;

endmodule

// File: rtl/fetch_pc_unit.sv
// Fetch stage: owns the PC, issues instruction-memory requests over a
// req/ack interface with wait states, and presents fetched instructions to
// decode through a registered output with stall hold, a one-entry skid
// buffer and redirect flush.
//   clk, reset          : clock, synchronous active-high reset
//   imem_req/addr       : fetch request, held with a stable address until ack
//   imem_ack/rdata      : one-cycle data-valid strobe and instruction word
//   instr_valid/instr   : decode-facing instruction and its valid
//   pc_plus4            : address of instr + 4
//   stall               : decode cannot accept this cycle
//   branch_taken, jump  : redirect requests (jump wins)
//   ex_pc_plus4, signimm_sh, jump_index : redirect target operands
module fetch_pc_unit
    import fetch_pc_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic               clk,
    input  logic               reset,
    output logic               imem_req,
    output logic [INSTR_W-1:0] imem_addr,
    input  logic               imem_ack,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic               instr_valid,
    output logic [INSTR_W-1:0] instr,
    output logic [INSTR_W-1:0] pc_plus4,
    input  logic               stall,
    input  logic               branch_taken,
    input  logic               jump,
    input  logic [INSTR_W-1:0] ex_pc_plus4,
    input  logic [INSTR_W-1:0] signimm_sh,
    input  logic [25:0]        jump_index
);

    fetch_state_e       r_state, w_state_nxt;
    logic [INSTR_W-1:0] r_pc, w_pc_nxt;
    logic [INSTR_W-1:0] r_redirect_pc, w_redirect_pc_nxt;
    logic [INSTR_W-1:0] r_skid_instr, w_skid_instr_nxt;
    logic [INSTR_W-1:0] r_skid_pc4, w_skid_pc4_nxt;
    logic [INSTR_W-1:0] r_instr, w_instr_nxt;
    logic [INSTR_W-1:0] r_pc_plus4, w_pc_plus4_nxt;
    logic               r_instr_valid, w_instr_valid_nxt;

    logic               w_redirect;
    logic               w_consume;
    logic [INSTR_W-1:0] w_target;
    logic [INSTR_W-1:0] w_pc_inc;

    pc_target_calc u_target (
        .ex_pc_plus4 (ex_pc_plus4),
        .signimm_sh  (signimm_sh),
        .jump_index  (jump_index),
        .jump        (jump),
        .target      (w_target)
    );

    assign w_redirect  = jump | branch_taken;
    assign w_consume   = r_instr_valid & ~stall;
    assign w_pc_inc    = r_pc + PC_INCR;

    // The request address is the PC register itself; the PC only moves on
    // ack or when no request is outstanding, which keeps the address stable.
    assign imem_addr   = r_pc;
    assign instr_valid = r_instr_valid;
    assign instr       = r_instr;
    assign pc_plus4    = r_pc_plus4;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= IDLE;
            r_pc          <= RESET_PC;
            r_redirect_pc <= '0;
            r_skid_instr  <= '0;
            r_skid_pc4    <= '0;
            r_instr       <= '0;
            r_pc_plus4    <= '0;
            r_instr_valid <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_pc          <= w_pc_nxt;
            r_redirect_pc <= w_redirect_pc_nxt;
            r_skid_instr  <= w_skid_instr_nxt;
            r_skid_pc4    <= w_skid_pc4_nxt;
            r_instr       <= w_instr_nxt;
            r_pc_plus4    <= w_pc_plus4_nxt;
            r_instr_valid <= w_instr_valid_nxt;
        end
    end

    always_comb begin
        w_state_nxt       = r_state;
        w_pc_nxt          = r_pc;
        w_redirect_pc_nxt = r_redirect_pc;
        w_skid_instr_nxt  = r_skid_instr;
        w_skid_pc4_nxt    = r_skid_pc4;
        w_instr_nxt       = r_instr;
        w_pc_plus4_nxt    = r_pc_plus4;
        w_instr_valid_nxt = r_instr_valid;
        imem_req          = 1'b0;

        // A consumed instruction leaves the output unless reloaded below.
        if (w_consume) begin
            w_instr_valid_nxt = 1'b0;
        end

        case (r_state)
            IDLE: begin
                w_state_nxt = FETCH;
            end

            FETCH: begin
                imem_req = 1'b1;
                if (w_redirect) begin
                    if (imem_ack) begin
                        w_pc_nxt = w_target;
                    end else begin
                        // Outstanding request must finish at its address first.
                        w_redirect_pc_nxt = w_target;
                        w_state_nxt       = DISCARD;
                    end
                end else if (imem_ack) begin
                    w_pc_nxt = w_pc_inc;
                    if (!r_instr_valid || !stall) begin
                        w_instr_nxt       = imem_rdata;
                        w_pc_plus4_nxt    = w_pc_inc;
                        w_instr_valid_nxt = 1'b1;
                    end else begin
                        w_skid_instr_nxt = imem_rdata;
                        w_skid_pc4_nxt   = w_pc_inc;
                        w_state_nxt      = HOLD;
                    end
                end
            end

            DISCARD: begin
                imem_req = 1'b1;
                if (w_redirect) begin
                    w_redirect_pc_nxt = w_target;
                end
                if (imem_ack) begin
                    w_pc_nxt    = w_redirect ? w_target : r_redirect_pc;
                    w_state_nxt = FETCH;
                end
            end

            HOLD: begin
                if (w_redirect) begin
                    w_pc_nxt    = w_target;
                    w_state_nxt = FETCH;
                end else if (!stall) begin
                    w_instr_nxt       = r_skid_instr;
                    w_pc_plus4_nxt    = r_skid_pc4;
                    w_instr_valid_nxt = 1'b1;
                    w_state_nxt       = FETCH;
                end
            end

            default: begin
                w_state_nxt = IDLE;
            end
        endcase

        // Wrong-path flush wins over stall and over any reload above.
        if (w_redirect) begin
            w_instr_valid_nxt = 1'b0;
        end
    end

endmodule

// File: doc/fetch_pc_unit.md
Name: fetch_pc_unit

Overview:
- Fetch stage directly downstream of the branch-offset shifter.
- Consumes the already-shifted branch immediate and forms branch and jump targets.
- Owns the PC register and drives a wait-state-capable instruction-memory request/ack interface.
- Presents fetched instructions to decode through a registered output with stall hold, a one-entry skid buffer and redirect flush.

Parameters:
RESET_PC, 32'h0000_0000, PC loaded on reset; first fetch address.

Ports:
clk  input  1  rising-edge clock
reset  input  1  synchronous, active-high reset
imem_req  output  1  fetch request; held until imem_ack
imem_addr  output  32  fetch address; stable while imem_req=1
imem_ack  input  1  one-cycle data-valid strobe; may arrive in the same cycle imem_req rises
imem_rdata  input  32  instruction word; valid when imem_ack=1
instr_valid  output  1  decode-facing instruction valid
instr  output  32  decode-facing instruction
pc_plus4  output  32  address of instr + 4
stall  input  1  decode cannot accept; consume = instr_valid & !stall
branch_taken  input  1  redirect to branch target this cycle
jump  input  1  redirect to jump target this cycle; wins over branch_taken
ex_pc_plus4  input  32  PC+4 of the redirecting instruction
signimm_sh  input  32  sign-extended immediate, already shifted left 2
jump_index  input  26  instruction bits [25:0]

Behaviour:
- Synchronous, active-high reset. All state updates on rising clk.
- Reset values:
  - pc=RESET_PC, state=IDLE.
  - imem_req=0, imem_addr=RESET_PC.
  - instr_valid=0, instr=0, pc_plus4=0, skid cleared.
  - Reset mid-request abandons the request; a late ack is ignored in IDLE.
- Targets, combinational, mod 2^32 with no overflow detection:
  - branch = ex_pc_plus4 + signimm_sh
  - jump = {ex_pc_plus4[31:28], jump_index, 2'b00}
  - redirect = jump | branch_taken; target selects jump when jump=1.
- imem_addr is registered from pc. imem_req is decoded from state.
- Any redirect clears instr_valid in the next cycle (wrong-path flush), regardless of stall.
- IDLE: req=0. Next cycle -> FETCH. First request goes out 1 cycle after reset deasserts.
- FETCH: req=1, addr=pc.
  - ack & redirect: drop rdata; pc<=target; stay FETCH. New address appears next cycle.
  - redirect & !ack: redirect_pc<=target -> DISCARD (address must stay stable).
  - ack, output free (!instr_valid | !stall): instr<=rdata, pc_plus4<=pc+4, instr_valid<=1, pc<=pc+4; stay FETCH.
  - ack, output blocked: skid<={rdata, pc+4}; pc<=pc+4 -> HOLD.
  - !ack & consume: instr_valid<=0.
  - Zero-wait memory yields one instruction per cycle. Latency from ack to instr_valid is 1 cycle.
- DISCARD: req=1, addr unchanged.
  - A newer redirect overwrites redirect_pc.
  - On ack: drop rdata; pc<=redirect_pc (or the new target if redirecting this cycle) -> FETCH.
- HOLD: req=0.
  - !stall: output<=skid, instr_valid<=1 -> FETCH.
  - redirect: discard skid; pc<=target -> FETCH.
- Simultaneous stall and redirect: redirect wins.
- Address wrap: pc+4 from 32'hFFFF_FFFC gives 0.
- Requests are never issued to a target while an older request is outstanding.

Decomposition:
- Shared package holds:
  - state enum {IDLE, FETCH, DISCARD, HOLD}
  - instruction width constant 32
  - PC increment constant 4
- One combinational sub-module, pc_target_calc: inputs ex_pc_plus4, signimm_sh, jump_index, jump; output target.
- FSM, pc, skid and output registers stay in fetch_pc_unit.

Test Plan:
1. Reset release, RESET_PC=0, zero-wait ack -> addr 0,4,8 on consecutive cycles; instr_valid from cycle 2; pc_plus4 4,8,C.
2. Ack two cycles after req, addr 0x100 -> addr held 0x100 for 3 cycles; instr_valid rises the cycle after ack; next req addr 0x104.
3. Branch mid-flight: ex_pc_plus4=0x200, signimm_sh=0xFFFF_FFF0 while req to 0x40 is unacked -> data for 0x40 dropped; next addr 0x1F0; instr_valid=0 until 0x1F0 data arrives.
4. Jump+branch same cycle: ex_pc_plus4=0x3000_0010, jump_index=0x000_0040 -> next addr 0x3000_0100.
5. stall=1 with instr_valid=1, then ack -> instr unchanged, imem_req drops (HOLD); stall released -> skid instruction presented next cycle; fetch resumes at pc+4.
6. Reset asserted during DISCARD with a late ack -> all outputs at reset values; ack ignored; first fetch at RESET_PC.
